// File: rtl/tile_color_arbiter.sv
// tile_color_arbiter: 16x12 playfield tile store with a tear-free write path.
// Game logic queues tile writes through a small FIFO. The FIFO drains into the
// tile store only during vertical blanking. A whole-grid clear can be armed at
// any time and executes at the start of the next vertical blank.
module tile_color_arbiter #(
   parameter int BSIZE      = 40,
   parameter int COLS       = 16,
   parameter int ROWS       = 12,
   parameter int HPIXELS    = 640,
   parameter int VLINES     = 480,
   parameter int HTOTAL     = 800,
   parameter int VTOTAL     = 525,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        vgaclk,
   input  logic        rst,
   input  logic [9:0]  hc,
   input  logic [9:0]  vc,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_tile,
   input  logic [11:0] wr_color,
   input  logic        clr_req,
   input  logic [11:0] clr_color,
   output logic        clr_busy,
   output logic [3:0]  red_in,
   output logic [3:0]  green_in,
   output logic [3:0]  blue_in,
   output logic        frame_done
);

   localparam int NTILES = COLS * ROWS;
   localparam int PW     = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, CLR_WAIT, CLEAR} state_t;

   state_t      state_reg;
   logic [7:0]  clr_idx_reg;
   logic [11:0] clr_color_reg;
   logic [11:0] tile_reg [NTILES];
   logic [19:0] fifo_reg [FIFO_DEPTH];
   logic [PW:0] wptr_reg;
   logic [PW:0] rptr_reg;
   logic        alive_reg;
   logic [11:0] color_reg;
   logic        frame_done_reg;

   logic        active;
   logic        vblank;
   logic        vblank_start;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push;
   logic        pop;
   logic [19:0] head;
   logic [9:0]  row_q;
   logic [9:0]  col_q;
   logic [7:0]  rd_idx;
   logic        ram_we;
   logic [7:0]  ram_waddr;
   logic [11:0] ram_wdata;

   assign active       = (hc < 10'(HPIXELS)) && (vc < 10'(VLINES));
   assign vblank       = (vc >= 10'(VLINES));
   assign vblank_start = (vc == 10'(VLINES)) && (hc == 10'd0);

   // Tile lookup: row-major index from exact pixel-to-tile division.
   assign row_q  = vc / 10'(BSIZE);
   assign col_q  = hc / 10'(BSIZE);
   assign rd_idx = 8'(row_q * 10'(COLS) + col_q);

   assign fifo_empty = (wptr_reg == rptr_reg);
   assign fifo_full  = (wptr_reg[PW] != rptr_reg[PW]) &&
                       (wptr_reg[PW-1:0] == rptr_reg[PW-1:0]);
   assign head       = fifo_reg[rptr_reg[PW-1:0]];

   // alive_reg holds wr_ready low while in reset and releases it one clock later.
   assign wr_ready = alive_reg && !fifo_full && (state_reg != CLEAR);
   assign push     = wr_valid && wr_ready;

   // The vblank_start cycle of a pending clear must not pop: anything popped
   // there would be overwritten by the clear instead of overriding it.
   assign pop = vblank && !fifo_empty &&
                ((state_reg == IDLE) || ((state_reg == CLR_WAIT) && !vblank_start));

   assign clr_busy   = (state_reg != IDLE);
   assign red_in     = color_reg[11:8];
   assign green_in   = color_reg[7:4];
   assign blue_in    = color_reg[3:0];
   assign frame_done = frame_done_reg;

   // Single tile-store write port: the clear sweep has priority, then FIFO pops.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = 8'd0;
      ram_wdata = 12'h000;
      if (state_reg == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_idx_reg;
         ram_wdata = clr_color_reg;
      end else if (pop && (head[19:12] < 8'(NTILES))) begin
         ram_we    = 1'b1;
         ram_waddr = head[19:12];
         ram_wdata = head[11:0];
      end
   end

   // Tile store; out-of-range popped entries never reach this port.
   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NTILES; i++) tile_reg[i] <= 12'h000;
      end else if (ram_we) begin
         tile_reg[ram_waddr] <= ram_wdata;
      end
   end

   // Write-request FIFO with one extra pointer bit to tell full from empty.
   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst) begin
         wptr_reg <= '0;
         rptr_reg <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_reg[i] <= 20'd0;
      end else begin
         if (push) begin
            fifo_reg[wptr_reg[PW-1:0]] <= {wr_tile, wr_color};
            wptr_reg                   <= wptr_reg + 1'b1;
         end
         if (pop) rptr_reg <= rptr_reg + 1'b1;
      end
   end

   // Clear sequencer: arm on request, start at vblank start, sweep every tile.
   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         clr_idx_reg   <= 8'd0;
         clr_color_reg <= 12'h000;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clr_req) begin
                  clr_color_reg <= clr_color;
                  state_reg     <= CLR_WAIT;
               end
            end
            CLR_WAIT: begin
               if (clr_req) clr_color_reg <= clr_color;
               if (vblank_start) begin
                  clr_idx_reg <= 8'd0;
                  state_reg   <= CLEAR;
               end
            end
            CLEAR: begin
               if (clr_idx_reg == 8'(NTILES - 1)) begin
                  clr_idx_reg <= 8'd0;
                  state_reg   <= IDLE;
               end else begin
                  clr_idx_reg <= clr_idx_reg + 8'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Registered pixel colour, forced black outside the active area.
   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst)        color_reg <= 12'h000;
      else if (active) color_reg <= tile_reg[rd_idx];
      else             color_reg <= 12'h000;
   end

   // End-of-frame strobe and post-reset ready enable.
   always_ff @(posedge vgaclk or negedge rst) begin
      if (!rst) begin
         frame_done_reg <= 1'b0;
         alive_reg      <= 1'b0;
      end else begin
         frame_done_reg <= (hc == 10'(HTOTAL - 1)) && (vc == 10'(VTOTAL - 1));
         alive_reg      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tile_color_arbiter.sv
// tb_tile_color_arbiter: directed and randomized stimulus for the tile arbiter,
// checked against a tile-grid model that applies queued writes and clears as
// whole vertical-blank transactions.
module tb_tile_color_arbiter;

   logic        vgaclk = 1'b0;
   logic        rst;
   logic [9:0]  hc;
   logic [9:0]  vc;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_tile;
   logic [11:0] wr_color;
   logic        clr_req;
   logic [11:0] clr_color;
   logic        clr_busy;
   logic [3:0]  red_in;
   logic [3:0]  green_in;
   logic [3:0]  blue_in;
   logic        frame_done;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   // Reference model: tile grid, queue of accepted writes, armed clear.
   logic [11:0] model_tile [192];
   int          q_tile [$];
   logic [11:0] q_color [$];
   bit          clr_pending;
   logic [11:0] clr_model_color;

   always #5 vgaclk = ~vgaclk;

   tile_color_arbiter dut (
      .vgaclk     (vgaclk),
      .rst        (rst),
      .hc         (hc),
      .vc         (vc),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_tile    (wr_tile),
      .wr_color   (wr_color),
      .clr_req    (clr_req),
      .clr_color  (clr_color),
      .clr_busy   (clr_busy),
      .red_in     (red_in),
      .green_in   (green_in),
      .blue_in    (blue_in),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge vgaclk);
      #1;
   endtask

   task automatic read_px(input int h, input int v, input string tag);
      logic [11:0] e;
      hc = 10'(h);
      vc = 10'(v);
      tick();
      if (h < 640 && v < 480) e = model_tile[(v / 40) * 16 + h / 40];
      else                    e = 12'h000;
      $display("read  hc=%0d vc=%0d rgb=%h", h, v, {red_in, green_in, blue_in});
      chk(tag, 32'({red_in, green_in, blue_in}), 32'(e));
   endtask

   task automatic check_grid(input string tag);
      for (int r = 0; r < 12; r++)
         for (int c = 0; c < 16; c++)
            read_px(c * 40 + int'($urandom_range(0, 39)), r * 40 + int'($urandom_range(0, 39)), tag);
   endtask

   // One push attempt; the model decides whether the FIFO has room.
   task automatic push(input int t, input logic [11:0] col);
      bit exp_rdy;
      exp_rdy  = (q_tile.size() < 4);
      wr_valid = 1'b1;
      wr_tile  = 8'(t);
      wr_color = col;
      chk("wr_ready_push", 32'(wr_ready), 32'(exp_rdy));
      tick();
      $display("push  tile=%0d color=%h accepted=%0d", t, col, exp_rdy);
      if (exp_rdy) begin
         q_tile.push_back(t);
         q_color.push_back(col);
      end
      wr_valid = 1'b0;
   endtask

   // Drive a blanking window long enough to finish any clear and drain.
   task automatic vblank_window(input int n);
      vc = 10'd480;
      for (int i = 0; i < n; i++) begin
         hc = 10'(i);
         tick();
      end
      if (clr_pending) begin
         for (int i = 0; i < 192; i++) model_tile[i] = clr_model_color;
         clr_pending = 1'b0;
      end
      while (q_tile.size() > 0) begin
         int          t;
         logic [11:0] c;
         t = q_tile.pop_front();
         c = q_color.pop_front();
         if (t < 192) model_tile[t] = c;
      end
      $display("vblank window of %0d clocks done", n);
      vc = 10'd100;
      hc = 10'd0;
   endtask

   initial begin
      int          t;
      logic [11:0] c;
      int          n;

      for (int i = 0; i < 192; i++) model_tile[i] = 12'h000;
      clr_pending     = 1'b0;
      clr_model_color = 12'h000;
      rst       = 1'b0;
      hc        = 10'd0;
      vc        = 10'd0;
      wr_valid  = 1'b0;
      wr_tile   = 8'd0;
      wr_color  = 12'h000;
      clr_req   = 1'b0;
      clr_color = 12'h000;

      // Reset state
      tick();
      tick();
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_clr_busy", 32'(clr_busy), 32'd0);
      chk("rst_rgb", 32'({red_in, green_in, blue_in}), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      rst = 1'b1;
      tick();
      chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
      check_grid("grid_after_reset");
      read_px(700, 100, "inactive_h");
      read_px(100, 500, "inactive_v");

      // frame_done strobe on the final counter value only
      hc = 10'd799; vc = 10'd524; tick();
      chk("frame_done_last", 32'(frame_done), 32'd1);
      hc = 10'd0; vc = 10'd0; tick();
      chk("frame_done_after", 32'(frame_done), 32'd0);
      hc = 10'd799; vc = 10'd523; tick();
      chk("frame_done_vc523", 32'(frame_done), 32'd0);
      hc = 10'd798; vc = 10'd524; tick();
      chk("frame_done_hc798", 32'(frame_done), 32'd0);

      // Tile 17 write is held until vertical blanking
      hc = 10'd300; vc = 10'd100;
      push(17, 12'hF00);
      read_px(40, 40, "t17_before_vblank");
      read_px(79, 79, "t17_before_vblank");
      vblank_window(8);
      read_px(40, 40, "t17_corner_a");
      read_px(79, 79, "t17_corner_b");
      read_px(60, 55, "t17_mid");
      read_px(80, 40, "t18_right_of_t17");
      read_px(39, 40, "t16_left_of_t17");

      // Five back-to-back pushes in active video: the fifth is refused
      hc = 10'd10; vc = 10'd200;
      for (int i = 0; i < 5; i++) push(int'($urandom_range(0, 191)), 12'($urandom));
      chk("queue_model_depth", 32'(q_tile.size()), 32'd4);
      vc = 10'd480; hc = 10'd0; tick();
      chk("ready_after_first_pop", 32'(wr_ready), 32'd1);
      vblank_window(8);
      check_grid("grid_after_burst");

      // Clear with one queued write that must override it
      hc = 10'd300; vc = 10'd200;
      clr_req   = 1'b1;
      clr_color = 12'h0A5;
      push(0, 12'hFFF);
      clr_req = 1'b0;
      clr_pending     = 1'b1;
      clr_model_color = 12'h0A5;
      chk("clr_busy_rise", 32'(clr_busy), 32'd1);
      read_px(20, 20, "old_t0_during_wait");
      read_px(60, 60, "old_t17_during_wait");
      vc = 10'd480; hc = 10'd0; tick();
      chk("clr_busy_at_start", 32'(clr_busy), 32'd1);
      for (int k = 1; k <= 192; k++) begin
         hc = 10'(k);
         tick();
         if (k == 1)   chk("wr_ready_in_clear", 32'(wr_ready), 32'd0);
         if (k >= 190) chk("clr_busy_tail", 32'(clr_busy), 32'(k < 192));
      end
      vblank_window(8);
      read_px(0, 0, "t0_override");
      check_grid("grid_after_clear");

      // Out-of-range entry is dropped; the following entry still lands
      hc = 10'd300; vc = 10'd100;
      t = int'($urandom_range(1, 191));
      c = 12'($urandom);
      push(200, 12'($urandom));
      push(t, c);
      vblank_window(8);
      read_px((t % 16) * 40 + 5, (t / 16) * 40 + 5, "after_bad_tile");
      check_grid("grid_after_bad_tile");

      // Randomized rounds, including occasional out-of-range tiles
      for (int r = 0; r < 3; r++) begin
         hc = 10'd100; vc = 10'd300;
         n = int'($urandom_range(1, 5));
         for (int i = 0; i < n; i++) push(int'($urandom_range(0, 255)), 12'($urandom));
         vblank_window(10);
         check_grid("grid_random_round");
      end

      // Reset during the clear sweep at index 100 abandons everything
      hc = 10'd300; vc = 10'd100;
      clr_req   = 1'b1;
      clr_color = 12'($urandom);
      tick();
      clr_req = 1'b0;
      push(5, 12'h123);
      vc = 10'd480; hc = 10'd0; tick();
      for (int k = 1; k <= 100; k++) begin
         hc = 10'(k);
         tick();
      end
      chk("busy_before_abort", 32'(clr_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("abort_clr_busy", 32'(clr_busy), 32'd0);
      chk("abort_wr_ready", 32'(wr_ready), 32'd0);
      chk("abort_rgb", 32'({red_in, green_in, blue_in}), 32'd0);
      chk("abort_frame_done", 32'(frame_done), 32'd0);
      for (int i = 0; i < 192; i++) model_tile[i] = 12'h000;
      q_tile.delete();
      q_color.delete();
      clr_pending = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("post_abort_ready", 32'(wr_ready), 32'd1);
      chk("post_abort_busy", 32'(clr_busy), 32'd0);
      vblank_window(8);
      chk("no_clear_resumed", 32'(clr_busy), 32'd0);
      check_grid("grid_after_abort");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/tile_color_arbiter.md
Name: tile_color_arbiter

Overview:
Owns the 16x12 grid of 40x40-pixel colour tiles that make up the playfield. It converts the timing generator's hc/vc counters into a tile lookup and drives the 12-bit colour into the VGA output stage's red_in/green_in/blue_in. Game logic writes tiles through a ready/valid FIFO, and all tile-RAM updates are committed only during vertical blanking, so no frame ever tears. It also provides a whole-grid clear command.

Parameters:
BSIZE, 40, tile edge in pixels
COLS, 16, tiles per row (HPIXELS/BSIZE)
ROWS, 12, tile rows (VLINES/BSIZE)
HPIXELS, 640, active pixels per line
VLINES, 480, active lines per frame
HTOTAL, 800, clocks per line including blanking
VTOTAL, 525, lines per frame including blanking
FIFO_DEPTH, 4, write-request FIFO entries (power of two)

Ports:
vgaclk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
hc  in  10  horizontal counter from the timing generator
vc  in  10  vertical counter from the timing generator
wr_valid  in  1  tile write request valid
wr_ready  out  1  FIFO can accept a request
wr_tile  in  8  tile index, row*COLS+col, legal range 0..191
wr_color  in  12  {R[11:8],G[7:4],B[3:0]}
clr_req  in  1  one-cycle pulse requesting a clear of all tiles
clr_color  in  12  fill colour, sampled with clr_req
clr_busy  out  1  clear is pending or executing
red_in  out  4  tile colour red, registered
green_in  out  4  tile colour green, registered
blue_in  out  4  tile colour blue, registered
frame_done  out  1  one-cycle pulse on the last clock of the frame

Behaviour:
- Reset is asynchronous and active-low. On reset: all 192 tile entries = 12'h000; FIFO empty; state IDLE; wr_ready=0 during reset and 1 from the first clock after release; clr_busy=0; red_in/green_in/blue_in=0; frame_done=0. A reset mid-clear or mid-drain aborts the operation, and no partial state survives.
- Read path: active = (hc<HPIXELS)&&(vc<VLINES). Tile index = (vc/BSIZE)*COLS + hc/BSIZE, computed with exact integer division. Colour is registered with 1-clock latency relative to hc/vc. When not active, the registered colour is 0.
- vblank = (vc>=VLINES). vblank_start = (vc==VLINES)&&(hc==0).
- FIFO: a push occurs when wr_valid&&wr_ready. wr_ready = !full && state!=CLEAR. Simultaneous push and pop are allowed. Order is strictly FIFO. A popped entry with wr_tile>191 is discarded and leaves the RAM unchanged.
- State machine (IDLE, CLR_WAIT, CLEAR):
  - IDLE: if vblank and FIFO not empty, pop one entry per clock and write it to RAM. An entry pushed this cycle is poppable on the next clock. On clr_req, latch clr_color and go to CLR_WAIT.
  - CLR_WAIT: the FIFO continues to accept pushes and drain in vblank. At vblank_start, go to CLEAR with index=0. A clr_req in this state re-latches the colour.
  - CLEAR: write the latched colour to tile[index], one tile per clock, for index 0..191. No FIFO pop and no push (wr_ready=0). After writing index 191, return to IDLE. Entries still in the FIFO then drain in the same vblank, after the clear, so queued writes override the clear. clr_req received while in CLEAR is ignored.
- clr_busy = (state!=IDLE). It is high on the clock after clr_req and low on the clock after the write to tile 191.
- frame_done pulses high for exactly one clock when hc==HTOTAL-1 && vc==VTOTAL-1. It is registered and asserts on the clock following that counter value.
- A RAM write and a read of the same tile in the same clock cannot occur, because writes happen only in vblank and reads only in active video.
- Arithmetic: the tile index is 8 bits (0..191). The clear index counts 0..191 and does not wrap.

Test Plan:
- Reset, then scan a full frame → colour is 0 everywhere; frame_done pulses once per 420000 clocks; wr_ready=1.
- Push tile 17 = 12'hF00 while vc=100 → RAM is unchanged until vc=480; next frame, hc=40..79 / vc=40..79 gives red_in=F and green_in=blue_in=0 one clock after hc/vc; hc=80 gives colour 0.
- Push 5 requests back-to-back with no vblank → first 4 are accepted; wr_ready=0 on the 5th; at vblank 4 pops occur on consecutive clocks and wr_ready returns to 1 after the first pop.
- clr_req with clr_color=12'h0A5 mid-frame, plus queued write tile 0 = 12'hFFF → clr_busy rises the next clock; clear runs 192 clocks from (vc=480,hc=0); tile 0 ends at FFF and all other tiles at 0A5.
- Pop with wr_tile=200 → no RAM change; a following entry is still applied.
- Assert rst low during CLEAR at index 100 → all outputs are 0 immediately; after release, every tile reads 0 and clr_busy=0.
